// File: rtl/str_dispatch.sv
// str_dispatch: upstream feeder of the PE router in the parallel string matcher.
// Packs a valid/ready character stream into blocks of `num` characters.
// Each block is presented to the PEs for pat_len compare cycles (ISSUE).
// The per-PE result is sampled one cycle later and reported with the block's text position.
// Optional feature: define MATCH_CNT_EN to add a saturating match counter port (match_cnt).
module str_dispatch #(
  parameter int DWIDTH  = 8,
  parameter int num     = 4,
  parameter int PAT_MAX = 16,
  parameter int PWIDTH  = 16,
  parameter int LWIDTH  = $clog2(PAT_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LWIDTH-1:0]     pat_len,
  input  logic                  in_valid,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [num*DWIDTH-1:0] str_arr,
  output logic [num-1:0]        ALU,
  output logic [num-1:0]        en,
  input  logic [num-1:0]        result,
  output logic                  match_valid,
  output logic [num-1:0]        match_vec,
  output logic [PWIDTH-1:0]     match_pos,
  output logic                  busy,
`ifdef MATCH_CNT_EN
  output logic [PWIDTH-1:0]     match_cnt,
`endif
  output logic                  done
);

  // Slot index width; a single-PE build still needs a one-bit counter.
  localparam int SWIDTH = (num > 1) ? $clog2(num) : 1;

  localparam logic [SWIDTH-1:0] SLOT_LAST = SWIDTH'(num - 1);
  localparam logic [LWIDTH-1:0] PAT_MAX_L = LWIDTH'(PAT_MAX);

  // Pass sequencing states.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [LWIDTH-1:0] len_reg;
  logic [LWIDTH-1:0] len_clamp;
  logic [LWIDTH-1:0] step_reg;
  logic [LWIDTH-1:0] step_last;
  logic [SWIDTH-1:0] slot_reg;
  logic              last_reg;
  logic [PWIDTH-1:0] base_reg;
  logic [num-1:0]    res_reg;

  // Per-slot storage of the block currently being built or issued.
  logic [DWIDTH-1:0] data_reg [num];
  logic              valid_reg [num];
  logic [num-1:0]    valid_vec;
  logic [num-1:0]    slot_hit;

  logic xfer;
  logic block_open;
  logic block_close;
  logic clear_valid;
  logic start_pass;

  // Handshake and per-cycle event decode.
  assign in_ready    = (state_reg == S_FILL);
  assign xfer        = in_valid & in_ready;
  assign block_open  = xfer && (slot_reg == '0);
  assign block_close = xfer && ((slot_reg == SLOT_LAST) || in_last);
  assign start_pass  = (state_reg == S_IDLE) && start;
  assign clear_valid = (state_reg == S_REPORT) || start_pass;
  assign step_last   = len_reg - LWIDTH'(1);

  // Clamp the requested pattern length to what the PE array supports.
  always_comb begin
    len_clamp = pat_len;
    if (pat_len > PAT_MAX_L) begin
      len_clamp = PAT_MAX_L;
    end
  end

  // Next-state decode for the pass sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (len_clamp == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (block_close) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (step_reg == step_last) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT:   state_next = S_REPORT;
      S_REPORT: state_next = last_reg ? S_DONE : S_FILL;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Sequencer state plus the pass-level counters (length, slot, step, block base).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      step_reg  <= '0;
      slot_reg  <= '0;
      last_reg  <= 1'b0;
      base_reg  <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            len_reg  <= len_clamp;
            step_reg <= '0;
            slot_reg <= '0;
            last_reg <= 1'b0;
            base_reg <= '0;
          end
        end
        S_FILL: begin
          if (xfer) begin
            if (block_close) begin
              slot_reg <= '0;
              last_reg <= in_last;
            end else begin
              slot_reg <= slot_reg + SWIDTH'(1);
            end
          end
        end
        S_ISSUE: begin
          step_reg <= (step_reg == step_last) ? '0 : step_reg + LWIDTH'(1);
        end
        S_WAIT: begin
          // Empty slots never report, whatever the router drives for them.
          res_reg <= result & valid_vec;
        end
        S_REPORT: begin
          base_reg <= base_reg + PWIDTH'(num);
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < num; gi++) begin : g_slot
      assign slot_hit[gi] = xfer && (slot_reg == SWIDTH'(gi));

      // Slot gi: capture its char; the first write of a new block blanks the other slots.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else begin
          if (slot_hit[gi]) begin
            data_reg[gi] <= in_data;
          end else if (block_open) begin
            data_reg[gi] <= '0;
          end
          if (slot_hit[gi]) begin
            valid_reg[gi] <= 1'b1;
          end else if (clear_valid) begin
            valid_reg[gi] <= 1'b0;
          end
        end
      end

      assign valid_vec[gi]                 = valid_reg[gi];
      assign str_arr[gi*DWIDTH +: DWIDTH]  = data_reg[gi];
    end
  endgenerate

  // PE control is only live during ISSUE; ALU restarts the accumulators on the first step.
  assign en  = (state_reg == S_ISSUE) ? valid_vec : '0;
  assign ALU = ((state_reg == S_ISSUE) && (step_reg == '0)) ? valid_vec : '0;

  // Report and status outputs; the report fields read zero outside the strobe.
  assign match_valid = (state_reg == S_REPORT);
  assign match_vec   = match_valid ? res_reg : '0;
  assign match_pos   = match_valid ? base_reg : '0;
  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);

`ifdef MATCH_CNT_EN
  localparam int CWIDTH = $clog2(num + 1);

  logic [CWIDTH-1:0] pop_cnt;
  logic [PWIDTH:0]   cnt_sum;
  logic [PWIDTH-1:0] cnt_reg;

  // Number of matching PEs in the block being reported.
  always_comb begin
    pop_cnt = '0;
    for (int k = 0; k < num; k++) begin
      pop_cnt = pop_cnt + CWIDTH'(res_reg[k]);
    end
  end

  assign cnt_sum = {1'b0, cnt_reg} + (PWIDTH + 1)'(pop_cnt);

  // Pass-wide match total, saturating at all-ones and held after the pass ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (start_pass) begin
      cnt_reg <= '0;
    end else if (state_reg == S_REPORT) begin
      cnt_reg <= cnt_sum[PWIDTH] ? '1 : cnt_sum[PWIDTH-1:0];
    end
  end

  assign match_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_str_dispatch.sv
// tb_str_dispatch: table-driven and randomized checks of str_dispatch against a
// block-level reference model (text split into groups of four, positions 0,4,8...).
module tb_str_dispatch;

  localparam int NUM    = 4;
  localparam int LWIDTH = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  pat_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] str_arr;
  logic [3:0]  alu;
  logic [3:0]  en;
  logic [3:0]  result;
  logic        match_valid;
  logic [3:0]  match_vec;
  logic [15:0] match_pos;
  logic        busy;
  logic        done;
`ifdef MATCH_CNT_EN
  logic [15:0] match_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pass_no     = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  vec;
    logic [15:0] pos;
    logic [31:0] data;
  } rep_t;

  typedef struct {
    int         pl;
    int         n;
    bit         gaps;
    int         mode;
    logic [3:0] forced;
    int         exp_len;
    int         exp_rep;
  } vec_t;

  rep_t exp_q[$];

  always #5 clk = ~clk;

  str_dispatch #(
    .DWIDTH(8), .num(NUM), .PAT_MAX(16), .PWIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pat_len(pat_len),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .str_arr(str_arr),
    .ALU(alu),
    .en(en),
    .result(result),
    .match_valid(match_valid),
    .match_vec(match_vec),
    .match_pos(match_pos),
    .busy(busy),
`ifdef MATCH_CNT_EN
    .match_cnt(match_cnt),
`endif
    .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Router stand-in: a PE "matches" when its char has odd parity; an empty slot says 1.
  function automatic logic [3:0] route(input logic [31:0] s);
    logic [3:0] r;
    logic [7:0] c;
    r = '0;
    for (int k = 0; k < NUM; k++) begin
      c = s[k*8 +: 8];
      r[k] = (c == 8'h00) ? 1'b1 : ^c;
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_str_arr"}, str_arr, 0);
    chk({tag, "_alu"}, alu, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_match_valid"}, match_valid, 0);
    chk({tag, "_match_vec"}, match_vec, 0);
    chk({tag, "_match_pos"}, match_pos, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // One full pass: model the expected reports, stream the text, act as router, check.
  task automatic run_pass(input vec_t v);
    logic [7:0] txt[$];
    rep_t       r;
    int         idx = 0;
    int         cyc = 0;
    int         reps = 0;
    int         issue_cnt = 0;
    int         exp_cnt = 0;
    bit         fin = 0;
    logic [3:0] en_prev = '0;

    for (int i = 0; i < v.n; i++) begin
      txt.push_back((v.mode != 0) ? 8'(8'h61 + i) : 8'($urandom_range(1, 255)));
    end

    exp_q.delete();
    for (int b = 0; b * NUM < v.n; b++) begin
      r.mask = '0;
      r.vec  = '0;
      r.data = '0;
      r.pos  = 16'(b * NUM);
      for (int k = 0; k < NUM; k++) begin
        if (b * NUM + k < v.n) begin
          r.mask[k]       = 1'b1;
          r.data[k*8 +: 8] = txt[b * NUM + k];
          r.vec[k]        = (v.mode != 0) ? v.forced[k] : ^txt[b * NUM + k];
        end
      end
      for (int k = 0; k < NUM; k++) exp_cnt += int'(r.vec[k]);
      exp_q.push_back(r);
    end

    @(negedge clk);
    start    = 1'b1;
    pat_len  = 5'(v.pl);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    start = 1'b0;

    while (!fin && cyc < 3000) begin
      cyc++;
      chk("busy_in_pass", busy, 1);
      if (match_valid && done) chk("mv_done_overlap", done, 0);
`ifdef MATCH_CNT_EN
      if (cyc == 1) chk("cnt_cleared_on_start", match_cnt, 0);
`endif
      if (en != 0) begin
        chk("ready_in_issue", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", en, 0);
        end else begin
          chk("en_mask", en, exp_q[0].mask);
          chk("str_arr", str_arr, exp_q[0].data);
          chk("alu", alu, (issue_cnt == 0) ? exp_q[0].mask : 4'h0);
        end
        issue_cnt++;
      end else begin
        chk("alu_quiet", alu, 0);
      end
      if (match_valid) begin
        chk("ready_in_report", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_report", match_valid, 0);
        end else begin
          r = exp_q.pop_front();
          chk("match_vec", match_vec, r.vec);
          chk("match_pos", match_pos, r.pos);
          chk("issue_cycles", issue_cnt, v.exp_len);
        end
        issue_cnt = 0;
        reps++;
      end
      if (done) begin
        chk("report_count", reps, v.exp_rep);
        chk("chars_taken", idx, v.n);
        if (!v.gaps) chk("done_cycle", cyc, v.n + v.exp_rep * (v.exp_len + 2) + 1);
`ifdef MATCH_CNT_EN
        chk("match_cnt", match_cnt, exp_cnt);
`endif
        fin = 1;
      end

      // Inputs for the coming rising edge.
      result  = (en_prev != 0 && en == 0) ? ((v.mode != 0) ? v.forced : route(str_arr))
                                          : 4'($urandom);
      en_prev = en;
      if (idx < v.n) begin
        in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = txt[idx];
        in_last  = (idx == v.n - 1);
        if (in_valid && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end
      if (!fin && v.gaps && $urandom_range(0, 9) == 0) begin
        start   = 1'b1;
        pat_len = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end

    if (!fin) chk("pass_timeout", done, 1);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
`ifdef MATCH_CNT_EN
    chk("match_cnt_held", match_cnt, exp_cnt);
`endif
    in_valid = 1'b0;
    start    = 1'b0;
    pass_no++;
    $display("pass %0d: pat_len=%0d chars=%0d gaps=%0d reports=%0d cycles=%0d",
             pass_no, v.pl, v.n, v.gaps, reps, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;

    tbl[0] = '{pl: 3,  n: 4,  gaps: 0, mode: 1, forced: 4'b0101, exp_len: 3,  exp_rep: 1};
    tbl[1] = '{pl: 2,  n: 8,  gaps: 1, mode: 0, forced: 4'b0000, exp_len: 2,  exp_rep: 2};
    tbl[2] = '{pl: 4,  n: 6,  gaps: 0, mode: 1, forced: 4'b1111, exp_len: 4,  exp_rep: 2};
    tbl[3] = '{pl: 0,  n: 0,  gaps: 0, mode: 0, forced: 4'b0000, exp_len: 0,  exp_rep: 0};
    tbl[4] = '{pl: 20, n: 4,  gaps: 0, mode: 0, forced: 4'b0000, exp_len: 16, exp_rep: 1};
    tbl[5] = '{pl: 31, n: 3,  gaps: 1, mode: 0, forced: 4'b0000, exp_len: 16, exp_rep: 1};
    tbl[6] = '{pl: 1,  n: 5,  gaps: 0, mode: 0, forced: 4'b0000, exp_len: 1,  exp_rep: 2};
    tbl[7] = '{pl: 16, n: 12, gaps: 1, mode: 0, forced: 4'b0000, exp_len: 16, exp_rep: 3};

    reset    = 1'b1;
    start    = 1'b0;
    pat_len  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    result   = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Reset in the middle of ISSUE aborts the pass with every output back at zero.
    @(negedge clk);
    start   = 1'b1;
    pat_len = 5'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 20 && en == 0; i++) begin
      in_data = 8'($urandom_range(1, 255));
      @(negedge clk);
    end
    chk("t1_issue_reached", en, 4'hF);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("t1_mid_issue_reset");
    $display("pass %0d: reset during ISSUE", ++pass_no);

    for (int t = 0; t < 8; t++) run_pass(tbl[t]);

    for (int t = 0; t < 30; t++) begin
      rv.pl      = $urandom_range(0, 24);
      rv.n       = (rv.pl == 0) ? 0 : $urandom_range(1, 13);
      rv.gaps    = 1'($urandom);
      rv.mode    = $urandom_range(0, 1);
      rv.forced  = 4'($urandom);
      rv.exp_len = (rv.pl > 16) ? 16 : rv.pl;
      rv.exp_rep = (rv.n + NUM - 1) / NUM;
      run_pass(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
